// File: rtl/stim_seq_pkg.sv
// Shared types, constants and the 6-bit LFSR step for the stimulus sequencer.
package stim_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } seq_state_e;

  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_INIT = 16'hFFFF;
  localparam logic [5:0]  EXH_LAST  = 6'h3F;
  localparam int          LFSR_LEN  = 63;

  // x^6+x^5+1, shift left; never reaches zero from a non-zero state
  function automatic logic [5:0] lfsr6_next(input logic [5:0] s);
    return {s[4:0], s[5] ^ s[0]};
  endfunction

endpackage

// File: rtl/sig_misr.sv
// 16-bit MISR folding the two DUT response bits into a running signature.
module sig_misr
  import stim_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        en,
  input  logic [1:0]  din,
  output logic [15:0] sig
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (clear) begin
      sig <= MISR_INIT;
    end else if (en) begin
      sig <= {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000) ^ {14'b0, din};
    end
  end

endmodule

// File: rtl/stim_sequencer.sv
// Drives a six-input combinational DUT vector by vector, waits DWELL cycles,
// then folds the sampled responses into a MISR signature.
module stim_sequencer
  import stim_seq_pkg::*;
#(
  parameter int DWELL = 10,
  parameter int SIG_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [5:0]       seed,
  input  logic [1:0]       resp,
  output logic [5:0]       stim,
  output logic             sample,
  output logic             busy,
  output logic             done,
  output logic [6:0]       vec_count,
  output logic [SIG_W-1:0] signature
);

  if (DWELL < 1 || DWELL > 255) begin : g_bad_dwell
    $error("stim_sequencer: DWELL must be in 1..255");
  end
  if (SIG_W != 16) begin : g_bad_sig_w
    $error("stim_sequencer: only SIG_W = 16 is supported");
  end

  localparam logic [7:0] DWELL_LOAD = 8'(DWELL - 1);

  seq_state_e state, state_nxt;
  logic [7:0] dwell_cnt;
  logic       mode_r;
  logic       launch;
  logic       last_vec;
  logic [5:0] stim_nxt;

  // start is only honoured when no run is in flight
  assign launch   = start && (state == IDLE || state == DONE);
  assign last_vec = mode_r ? (vec_count == 7'(LFSR_LEN - 1)) : (stim == EXH_LAST);
  assign stim_nxt = mode_r ? lfsr6_next(stim) : stim + 6'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = APPLY;
      APPLY:      if (dwell_cnt == 8'd0) state_nxt = SAMPLE;
      SAMPLE:     state_nxt = last_vec ? DONE : APPLY;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sample = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (state)
      APPLY:   busy = 1'b1;
      SAMPLE:  begin busy = 1'b1; sample = 1'b1; end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stim      <= '0;
      dwell_cnt <= '0;
      vec_count <= '0;
      mode_r    <= 1'b0;
    end else if (launch) begin
      stim      <= mode ? ((seed == 6'h00) ? 6'h01 : seed) : 6'h00;
      mode_r    <= mode;
      vec_count <= '0;
      dwell_cnt <= DWELL_LOAD;
    end else begin
      case (state)
        APPLY: if (dwell_cnt != 8'd0) dwell_cnt <= dwell_cnt - 8'd1;
        SAMPLE: begin
          vec_count <= vec_count + 7'd1;
          // the final vector stays on stim through DONE
          if (!last_vec) begin
            stim      <= stim_nxt;
            dwell_cnt <= DWELL_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

  sig_misr u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (launch),
    .en    (state == SAMPLE),
    .din   (resp),
    .sig   (signature)
  );

endmodule

// File: tb/tb_stim_sequencer.sv
// Directed bench for stim_sequencer: exhaustive and LFSR runs at DWELL=1 and
// a golden gate-level model driven at DWELL=10.
module tb_stim_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       start1 = 1'b0, mode1 = 1'b0;
  logic [5:0] seed1 = '0;
  logic [1:0] resp1 = '0;
  logic [5:0] stim1;
  logic       sample1, busy1, done1;
  logic [6:0] vc1;
  logic [15:0] sig1;

  logic       start10 = 1'b0, mode10 = 1'b0;
  logic [5:0] seed10 = '0;
  logic [1:0] resp10;
  logic [5:0] stim10;
  logic       sample10, busy10, done10;
  logic [6:0] vc10;
  logic [15:0] sig10;

  int n_cmp = 0;
  int n_bad = 0;
  logic [5:0] seq_log [64];

  stim_sequencer #(.DWELL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode1), .seed(seed1),
    .resp(resp1), .stim(stim1), .sample(sample1), .busy(busy1), .done(done1),
    .vec_count(vc1), .signature(sig1)
  );

  stim_sequencer #(.DWELL(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .start(start10), .mode(mode10), .seed(seed10),
    .resp(resp10), .stim(stim10), .sample(sample10), .busy(busy10), .done(done10),
    .vec_count(vc10), .signature(sig10)
  );

  function automatic logic [1:0] gate_fn(input logic [5:0] v);
    logic a, b, c, d, e, f;
    {a, b, c, d, e, f} = v;
    return {(a & b) | (c ^ (d & e)), ~((a | f) & (b ^ e))};
  endfunction

  assign resp10 = gate_fn(stim10);

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [1:0] r);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {14'b0, r};
  endfunction

  function automatic logic [5:0] lfsr6(input logic [5:0] s);
    return {s[4:0], s[5] ^ s[0]};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run1(input logic m, input logic [5:0] sd, input logic [1:0] r,
                      input int nvec, output logic [15:0] first_sig,
                      output logic [15:0] final_sig);
    logic [5:0]  v;
    logic [15:0] es;
    logic [63:0] seen;
    int          reps;
    mode1 = m; seed1 = sd; resp1 = r; start1 = 1'b1;
    tick();
    start1 = 1'b0; mode1 = ~m; seed1 = ~sd;
    es = 16'hFFFF; seen = '0; reps = 0; first_sig = '0;
    v = m ? ((sd == 6'h00) ? 6'h01 : sd) : 6'h00;
    check_val("start_sig", sig1, 16'hFFFF);
    check_val("start_cnt", vc1, 0);
    check_val("start_busy", busy1, 1);
    for (int k = 0; k < nvec; k++) begin
      seq_log[k] = stim1;
      check_val("apply_stim", stim1, v);
      check_val("apply_sample", sample1, 0);
      tick();
      check_val("sample_stim", stim1, v);
      check_val("sample_pulse", sample1, 1);
      check_val("sample_done", done1, 0);
      if (seen[v]) reps++;
      seen[v] = 1'b1;
      if (k == nvec - 1) start1 = 1'b1;
      tick();
      es = misr_step(es, r);
      if (k == 0) first_sig = sig1;
      check_val("vec_cnt", vc1, k + 1);
      if (k < nvec - 1) v = m ? lfsr6(v) : v + 6'd1;
    end
    start1 = 1'b0;
    check_val("end_sig", sig1, es);
    check_val("end_done", done1, 1);
    check_val("end_busy", busy1, 0);
    check_val("end_stim", stim1, v);
    check_val("repeats", reps, 0);
    tick();
    check_val("hold_done", done1, 1);
    check_val("hold_cnt", vc1, nvec);
    check_val("hold_sig", sig1, es);
    final_sig = sig1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] fs, fin, fin_a, fin_b, model;
    logic [5:0]  lf_exp [7];
    logic [5:0]  saved [64];
    int          diffs, cycles;
    lf_exp = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3F, 6'h3E};

    #2 rst_n = 1'b0;
    #1;
    check_val("rst_stim", stim1, 0);
    check_val("rst_busy", busy1, 0);
    check_val("rst_done", done1, 0);
    check_val("rst_sample", sample1, 0);
    check_val("rst_cnt", vc1, 0);
    check_val("rst_sig", sig1, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // exhaustive, resp 00
    run1(1'b0, 6'h00, 2'b00, 64, fs, fin);
    check_val("first_sig_00", fs, 16'hEFDF);

    // resp 11 from DONE, then reset mid-vector
    resp1 = 2'b11; mode1 = 1'b0; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    tick();
    check_val("first_sig_11", sig1, 16'hEFDC);
    check_val("second_vec", stim1, 6'h01);
    check_val("mid_busy", busy1, 1);
    rst_n = 1'b0;
    #1;
    check_val("mrst_stim", stim1, 0);
    check_val("mrst_busy", busy1, 0);
    check_val("mrst_done", done1, 0);
    check_val("mrst_sample", sample1, 0);
    check_val("mrst_cnt", vc1, 0);
    check_val("mrst_sig", sig1, 0);
    #1 rst_n = 1'b1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check_val("restart_stim", stim1, 6'h00);
    check_val("restart_busy", busy1, 1);
    check_val("restart_sig", sig1, 16'hFFFF);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    #1;

    // LFSR, seed 01
    run1(1'b1, 6'h01, 2'b01, 63, fs, fin_a);
    for (int i = 0; i < 7; i++) check_val("lfsr_seq", seq_log[i], lf_exp[i]);
    for (int i = 0; i < 63; i++) saved[i] = seq_log[i];

    // LFSR, seed 00 behaves as seed 01
    run1(1'b1, 6'h00, 2'b01, 63, fs, fin_b);
    check_val("seed0_first", seq_log[0], 6'h01);
    diffs = 0;
    for (int i = 0; i < 63; i++) if (seq_log[i] != saved[i]) diffs++;
    check_val("seed0_seq", diffs, 0);
    check_val("seed0_sig", fin_b, fin_a);

    // golden gate model at DWELL=10
    model = 16'hFFFF;
    for (int v = 0; v < 64; v++) model = misr_step(model, gate_fn(6'(v)));
    start10 = 1'b1;
    tick();
    start10 = 1'b0;
    check_val("g_busy", busy10, 1);
    cycles = 0;
    while (!done10 && cycles < 3000) begin
      tick();
      cycles++;
      if (cycles == 100) start10 = 1'b1;
      else if (cycles == 101) start10 = 1'b0;
    end
    check_val("g_run_len", cycles, 704);
    check_val("g_sig", sig10, model);
    check_val("g_cnt", vc10, 64);
    check_val("g_busy_low", busy10, 0);
    start10 = 1'b1;
    tick();
    start10 = 1'b0;
    check_val("g_rerun_sig", sig10, 16'hFFFF);
    check_val("g_rerun_busy", busy10, 1);
    check_val("g_rerun_cnt", vc10, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
